// File: rtl/mbc5x.sv
// Purpose: MBC5-class cartridge bank controller with optional MBC3-style RTC.
// Latency: register writes commit on the falling-wr edge cycle; roma/rama/ramsel/doe are combinational, dout is 1 cycle.
// Backpressure: none; the cartridge bus never stalls, one commit per wr strobe.
//
// Ports:
//   phi          bus clock, all state on rising edge
//   rst          synchronous reset, active-low
//   addr[3:0]    bus address bits [15:12]
//   data[7:0]    bus write data
//   cs, rd, wr   bus SRAM select / read / write strobes, active-low
//   roma         ROM bank address bits [ROM_BANK_W+13:14]
//   rama         SRAM bank address bits [RAM_BANK_W+12:13]
//   ramsel       SRAM chip-select, active-low
//   dout, doe    RTC read data and its output enable (active-high)
//
// Build option: define MBC5X_RTC_EN to include the real-time clock, its latch
// sequence and the dout/doe read path. Without it those outputs are tied off.

module mbc5x #(
    parameter int ROM_BANK_W = 9,
    parameter int RAM_BANK_W = 4,
    parameter int TICK_DIV   = 1048576
) (
    input  logic                  phi,
    input  logic                  rst,
    input  logic [3:0]            addr,
    input  logic [7:0]            data,
    input  logic                  cs,
    input  logic                  rd,
    input  logic                  wr,
    output logic [ROM_BANK_W-1:0] roma,
    output logic [RAM_BANK_W-1:0] rama,
    output logic                  ramsel,
    output logic [7:0]            dout,
    output logic                  doe
);

    // ------------------------------------------------------------------
    // Write strobe edge detect. wr_q resets low so a strobe that is still
    // held low when reset releases needs a fresh high->low edge to commit.
    // ------------------------------------------------------------------
    logic wr_q;
    logic commit;
    logic ram_win;

    assign commit  = !wr && wr_q;
    assign ram_win = (addr[3:1] == 3'b101);

    // ------------------------------------------------------------------
    // Banking registers
    // ------------------------------------------------------------------
    logic                  ramen_q, ramen_d;
    logic [ROM_BANK_W-1:0] romb_q,  romb_d;
    logic [RAM_BANK_W-1:0] rama_q,  rama_d;
    logic                  rtcsel;
    logic [8:0]            romb_ext;

`ifdef MBC5X_RTC_EN
    logic       rtcsel_q, rtcsel_d;
    logic [2:0] rtcreg_q, rtcreg_d;
    assign rtcsel = rtcsel_q;
`else
    assign rtcsel = 1'b0;
`endif

    always_comb begin
        ramen_d  = ramen_q;
        rama_d   = rama_q;
        romb_ext = 9'(romb_q);
`ifdef MBC5X_RTC_EN
        rtcsel_d = rtcsel_q;
        rtcreg_d = rtcreg_q;
`endif
        if (commit) begin
            case (addr[3:1])
                3'b000: ramen_d = (data == 8'h0A);
                3'b001: begin
                    if (!addr[0]) begin
                        romb_ext[7:0] = data;
                    end else if (ROM_BANK_W > 8) begin
                        romb_ext[8] = data[0];
                    end
                end
                3'b010: begin
`ifdef MBC5X_RTC_EN
                    if (data[3]) begin
                        rtcsel_d = 1'b1;
                        rtcreg_d = data[2:0];
                    end else begin
                        rtcsel_d = 1'b0;
                        rama_d   = data[RAM_BANK_W-1:0];
                    end
`else
                    rama_d = data[RAM_BANK_W-1:0];
`endif
                end
                default: ;
            endcase
        end
        romb_d = romb_ext[ROM_BANK_W-1:0];
    end

    // Bank 0 is deliberately selectable in the upper window (no 0->1 remap).
    assign roma   = addr[2] ? romb_q : '0;
    assign rama   = rama_q;
    assign ramsel = cs | !ramen_q | !ram_win | rtcsel | (rd & wr);

`ifdef MBC5X_RTC_EN
    // ------------------------------------------------------------------
    // Real-time clock
    // ------------------------------------------------------------------
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        LAT_IDLE  = 1'b0,
        LAT_ARMED = 1'b1
    } lat_state_t;

    lat_state_t    lat_st_q, lat_st_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [8:0]    day_q, day_d;
    logic          halt_q, halt_d, carry_q, carry_d;
    logic [5:0]    lsec_q, lsec_d, lmin_q, lmin_d;
    logic [4:0]    lhour_q, lhour_d;
    logic [8:0]    lday_q, lday_d;
    logic          lhalt_q, lhalt_d, lcarry_q, lcarry_d;
    logic [7:0]    dout_q, dout_d;

    logic rtc_wr, wr_sec, wr_min, wr_hour, wr_dlo, wr_flag;
    logic tick, sec_co, min_co, hour_co, day_co;
    logic do_latch;

    assign rtc_wr  = commit && rtcsel_q && ramen_q && ram_win;
    assign wr_sec  = rtc_wr && (rtcreg_q == 3'd0);
    assign wr_min  = rtc_wr && (rtcreg_q == 3'd1);
    assign wr_hour = rtc_wr && (rtcreg_q == 3'd2);
    assign wr_dlo  = rtc_wr && (rtcreg_q == 3'd3);
    assign wr_flag = rtc_wr && (rtcreg_q == 3'd4);

    assign tick = !halt_q && (presc_q == PRESC_MAX);

    // Carry chain. A field being written by the CPU takes the written value,
    // so it neither consumes its carry-in nor produces a carry-out. A field
    // above its max simply counts on modulo 2^width and never reaches the
    // exact max compare, hence no carry-out.
    assign sec_co  = tick    && (sec_q  == 6'd59)   && !wr_sec;
    assign min_co  = sec_co  && (min_q  == 6'd59)   && !wr_min;
    assign hour_co = min_co  && (hour_q == 5'd23)   && !wr_hour;
    assign day_co  = hour_co && (day_q  == 9'd511)  && !wr_dlo && !wr_flag;

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        halt_d  = halt_q;
        carry_d = carry_q;
        presc_d = presc_q;

        if (wr_sec) begin
            presc_d = '0;
        end else if (!halt_q) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end

        if (wr_sec)           sec_d = data[5:0];
        else if (tick)        sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;

        if (wr_min)           min_d = data[5:0];
        else if (sec_co)      min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;

        if (wr_hour)          hour_d = data[4:0];
        else if (min_co)      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;

        // Day is split across two register indices; each write touches only
        // its own part.
        if (wr_dlo)           day_d = {day_q[8], data};
        else if (wr_flag)     day_d = {data[0], day_q[7:0]};
        else if (hour_co)     day_d = day_q + 9'd1;

        if (wr_flag) begin
            halt_d  = data[6];
            carry_d = data[7];
        end else if (day_co) begin
            carry_d = 1'b1;
        end
    end

    // Latch sequence: 00 arms, 01 while armed captures, anything else disarms.
    always_comb begin
        lat_st_d = lat_st_q;
        do_latch = 1'b0;
        if (commit && (addr[3:1] == 3'b011)) begin
            if (data == 8'h00) begin
                lat_st_d = LAT_ARMED;
            end else if ((data == 8'h01) && (lat_st_q == LAT_ARMED)) begin
                lat_st_d = LAT_IDLE;
                do_latch = 1'b1;
            end else begin
                lat_st_d = LAT_IDLE;
            end
        end
    end

    // Capture uses the current (pre-tick) live values.
    always_comb begin
        lsec_d   = do_latch ? sec_q   : lsec_q;
        lmin_d   = do_latch ? min_q   : lmin_q;
        lhour_d  = do_latch ? hour_q  : lhour_q;
        lday_d   = do_latch ? day_q   : lday_q;
        lhalt_d  = do_latch ? halt_q  : lhalt_q;
        lcarry_d = do_latch ? carry_q : lcarry_q;
    end

    always_comb begin
        case (rtcreg_q)
            3'd0:    dout_d = {2'b00, lsec_q};
            3'd1:    dout_d = {2'b00, lmin_q};
            3'd2:    dout_d = {3'b000, lhour_q};
            3'd3:    dout_d = lday_q[7:0];
            3'd4:    dout_d = {lcarry_q, lhalt_q, 5'b00000, lday_q[8]};
            default: dout_d = 8'hFF;
        endcase
    end

    assign dout = dout_q;
    assign doe  = rtcsel_q & ramen_q & !cs & !rd & ram_win;

    always_ff @(posedge phi) begin
        if (!rst) begin
            rtcsel_q <= 1'b0;
            rtcreg_q <= 3'd0;
            lat_st_q <= LAT_IDLE;
            presc_q  <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            day_q    <= '0;
            halt_q   <= 1'b0;
            carry_q  <= 1'b0;
            lsec_q   <= '0;
            lmin_q   <= '0;
            lhour_q  <= '0;
            lday_q   <= '0;
            lhalt_q  <= 1'b0;
            lcarry_q <= 1'b0;
            dout_q   <= 8'h00;
        end else begin
            rtcsel_q <= rtcsel_d;
            rtcreg_q <= rtcreg_d;
            lat_st_q <= lat_st_d;
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            day_q    <= day_d;
            halt_q   <= halt_d;
            carry_q  <= carry_d;
            lsec_q   <= lsec_d;
            lmin_q   <= lmin_d;
            lhour_q  <= lhour_d;
            lday_q   <= lday_d;
            lhalt_q  <= lhalt_d;
            lcarry_q <= lcarry_d;
            dout_q   <= dout_d;
        end
    end
`else
    assign dout = 8'h00;
    assign doe  = 1'b0;
`endif

    always_ff @(posedge phi) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            ramen_q <= 1'b0;
            romb_q  <= ROM_BANK_W'(1);
            rama_q  <= '0;
        end else begin
            wr_q    <= wr;
            ramen_q <= ramen_d;
            romb_q  <= romb_d;
            rama_q  <= rama_d;
        end
    end

endmodule

// File: tb/tb_mbc5x.sv
module tb_mbc5x;

    logic       phi = 1'b0;
    logic       rst;
    logic [3:0] addr;
    logic [7:0] data;
    logic       cs, rd, wr;
    logic [8:0] roma;
    logic [3:0] rama;
    logic       ramsel;
    logic [7:0] dout;
    logic       doe;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    mbc5x #(.ROM_BANK_W(9), .RAM_BANK_W(4), .TICK_DIV(4)) dut (
        .phi(phi), .rst(rst), .addr(addr), .data(data), .cs(cs), .rd(rd), .wr(wr),
        .roma(roma), .rama(rama), .ramsel(ramsel), .dout(dout), .doe(doe)
    );

    always #5 phi = ~phi;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_bad++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    // One strobe: commit happens on the posedge following the first negedge.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge phi);
        addr = a;
        data = d;
        wr   = 1'b0;
        @(negedge phi);
        wr   = 1'b1;
    endtask

`ifdef MBC5X_RTC_EN
    task automatic rtc_wr(input logic [2:0] idx, input logic [7:0] v);
        bus_write(4'h4, {5'b00001, idx});
        bus_write(4'hA, v);
    endtask

    task automatic rtc_latch();
        bus_write(4'h6, 8'h00);
        bus_write(4'h6, 8'h01);
    endtask

    task automatic rtc_rd(input logic [2:0] idx, output logic [7:0] v);
        bus_write(4'h4, {5'b00001, idx});
        @(negedge phi);
        addr = 4'hA;
        cs   = 1'b0;
        rd   = 1'b0;
        #1;
        expect_val(32'd1);
        check("rtc_doe", {31'd0, doe});
        v  = dout;
        cs = 1'b1;
        rd = 1'b1;
    endtask

    logic [7:0] rv;
`endif

    initial begin
        rst  = 1'b0;
        addr = 4'h0;
        data = 8'h00;
        cs   = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;
        repeat (3) @(negedge phi);
        rst = 1'b1;
        @(negedge phi);

        // Reset state
        addr = 4'h0; #1;
        expect_val(32'h000); check("rst_roma_lo", {23'd0, roma});
        expect_val(32'd1);   check("rst_ramsel", {31'd0, ramsel});
        expect_val(32'd0);   check("rst_doe", {31'd0, doe});
        addr = 4'h4; #1;
        expect_val(32'h001); check("rst_roma_hi", {23'd0, roma});

        // ROM bank low + high byte
        bus_write(4'h2, 8'h34);
        bus_write(4'h3, 8'h01);
        addr = 4'h4; #1;
        expect_val(32'h134); check("roma_134", {23'd0, roma});
        addr = 4'h0; #1;
        expect_val(32'h000); check("roma_lower_win", {23'd0, roma});

        // Bank 0 stays selectable in the upper window
        bus_write(4'h3, 8'h00);
        bus_write(4'h2, 8'h00);
        addr = 4'h5; #1;
        expect_val(32'h000); check("roma_bank0", {23'd0, roma});
        bus_write(4'h3, 8'h01);
        bus_write(4'h2, 8'h34);

        // RAM enable and select
        bus_write(4'h0, 8'h0A);
        bus_write(4'h4, 8'h05);
        addr = 4'hA; cs = 1'b0; rd = 1'b0; #1;
        expect_val(32'd0); check("ramsel_en", {31'd0, ramsel});
        expect_val(32'h5); check("rama_5", {28'd0, rama});
        addr = 4'hC; #1;
        expect_val(32'd1); check("ramsel_addr_out", {31'd0, ramsel});
        bus_write(4'h0, 8'h0B);
        addr = 4'hA; #1;
        expect_val(32'd1); check("ramsel_dis", {31'd0, ramsel});
        cs = 1'b1; rd = 1'b1;

        // data[3] in a RAM-bank write
        bus_write(4'h0, 8'h0A);
        bus_write(4'h4, 8'h0D);
        @(negedge phi);
        addr = 4'hA; cs = 1'b0; rd = 1'b0; #1;
`ifdef MBC5X_RTC_EN
        expect_val(32'd1);  check("rtcsel_ramsel", {31'd0, ramsel});
        expect_val(32'h5);  check("rama_kept", {28'd0, rama});
        expect_val(32'd1);  check("doe_rtc", {31'd0, doe});
        expect_val(32'hFF); check("dout_idx5", {24'd0, dout});
        cs = 1'b1; rd = 1'b1;
        bus_write(4'h4, 8'h03);
        addr = 4'hA; cs = 1'b0; rd = 1'b0; #1;
        expect_val(32'd0);  check("ramsel_back", {31'd0, ramsel});
        expect_val(32'h3);  check("rama_3", {28'd0, rama});
        expect_val(32'd0);  check("doe_off", {31'd0, doe});
`else
        expect_val(32'hD);  check("rama_bit3", {28'd0, rama});
        expect_val(32'd0);  check("ramsel_bit3", {31'd0, ramsel});
        expect_val(32'd0);  check("doe_none", {31'd0, doe});
        expect_val(32'h00); check("dout_none", {24'd0, dout});
`endif
        cs = 1'b1; rd = 1'b1;

        // Single commit per strobe
        @(negedge phi);
        addr = 4'h2; data = 8'h10; wr = 1'b0;
        @(negedge phi);
        data = 8'h20;
        repeat (9) @(negedge phi);
        wr = 1'b1;
        @(negedge phi);
        addr = 4'h4; #1;
        expect_val(32'h110); check("single_commit", {23'd0, roma});

        // Reset during a strobe; strobe still low after release must not commit
        @(negedge phi);
        addr = 4'h2; data = 8'h55; wr = 1'b0; rst = 1'b0;
        repeat (2) @(negedge phi);
        rst = 1'b1;
        repeat (3) @(negedge phi);
        wr = 1'b1;
        @(negedge phi);
        addr = 4'h4; #1;
        expect_val(32'h001); check("rst_mid_strobe", {23'd0, roma});
        addr = 4'hA; cs = 1'b0; rd = 1'b0; #1;
        expect_val(32'd1); check("rst_ramen_off", {31'd0, ramsel});
        cs = 1'b1; rd = 1'b1;

`ifdef MBC5X_RTC_EN
        bus_write(4'h0, 8'h0A);

        // Rollover of every field; unhalt is the last commit, first tick 4 edges later
        rtc_wr(3'd4, 8'h41);
        rtc_wr(3'd0, 8'd59);
        rtc_wr(3'd1, 8'd59);
        rtc_wr(3'd2, 8'd23);
        rtc_wr(3'd3, 8'hFF);
        rtc_wr(3'd4, 8'h01);
        repeat (2) @(negedge phi);
        rtc_latch();
        rtc_rd(3'd4, rv); expect_val(32'h80); check("roll_flags", {24'd0, rv});
        rtc_rd(3'd0, rv); expect_val(32'h00); check("roll_sec", {24'd0, rv});
        rtc_rd(3'd1, rv); expect_val(32'h00); check("roll_min", {24'd0, rv});
        rtc_rd(3'd2, rv); expect_val(32'h00); check("roll_hour", {24'd0, rv});
        rtc_rd(3'd3, rv); expect_val(32'h00); check("roll_day", {24'd0, rv});

        // Halt freezes the counters; a broken latch sequence does not capture
        rtc_wr(3'd4, 8'h40);
        rtc_wr(3'd0, 8'd33);
        rtc_latch();
        repeat (12) @(negedge phi);
        rtc_latch();
        rtc_rd(3'd0, rv); expect_val(32'd33); check("halt_sec", {24'd0, rv});
        rtc_rd(3'd4, rv); expect_val(32'h40); check("halt_flags", {24'd0, rv});
        rtc_wr(3'd0, 8'd5);
        bus_write(4'h6, 8'h00);
        bus_write(4'h6, 8'h02);
        bus_write(4'h6, 8'h01);
        rtc_rd(3'd0, rv); expect_val(32'd33); check("latch_broken", {24'd0, rv});
        rtc_latch();
        rtc_rd(3'd0, rv); expect_val(32'd5); check("latch_ok", {24'd0, rv});

        // Out-of-range seconds: 62 -> 63 -> 0 with no carry into minutes
        rtc_wr(3'd1, 8'd10);
        rtc_wr(3'd0, 8'd62);
        rtc_wr(3'd4, 8'h00);
        repeat (6) @(negedge phi);
        rtc_latch();
        rtc_rd(3'd0, rv); expect_val(32'd0);  check("oor_sec", {24'd0, rv});
        rtc_rd(3'd1, rv); expect_val(32'd10); check("oor_min", {24'd0, rv});
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mbc5x.md
# mbc5x

Parametrised successor to the MBC5-class GameBoy memory bank controller. It decodes cartridge-bus writes into ROM bank, RAM bank and RAM-enable registers, with ROM and RAM bank widths set by parameter. It optionally adds an MBC3-style real-time clock (RTC) with a latch sequence, halt and day-carry. The block sits between the cartridge edge connector and the ROM/SRAM chips. All state is synchronous to `phi`.

## Interface
- `ROM_BANK_W`, 9: ROM bank register width, 2..9; max ROM = 2^ROM_BANK_W × 16 KiB.
- `RAM_BANK_W`, 4: RAM bank register width, 1..4.
- `TICK_DIV`, 1048576: `phi` cycles per RTC second; must be ≥ 2.
- `phi`  in  1: clock; bus clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `addr`  in  4: bus address bits [15:12].
- `data`  in  8: bus write data.
- `cs`  in  1: SRAM chip-select from bus, active-low.
- `rd`  in  1: read strobe, active-low.
- `wr`  in  1: write strobe, active-low.
- `roma`  out  ROM_BANK_W: ROM address bits [ROM_BANK_W+13:14].
- `rama`  out  RAM_BANK_W: SRAM address bits [RAM_BANK_W+12:13].
- `ramsel`  out  1: SRAM chip-select, active-low.
- `dout`  out  8: RTC read data.
- `doe`  out  1: drive `dout` onto bus, active-high.

## Operation
- Write commit: `wr` is registered each cycle as `wr_q`. A commit fires on the cycle where `wr`=0 and `wr_q`=1. `addr` and `data` are sampled on that same cycle. Only one commit happens per strobe.
- `addr` 000x: `ramen` = (`data`==8'h0A).
- `addr` 0010: `romb[7:0]` = `data`.
- `addr` 0011: `romb[ROM_BANK_W-1:8]` = `data[ROM_BANK_W-9:0]`; ignored if ROM_BANK_W ≤ 8.
- `addr` 010x:
  - If `data[3]`=1 and RTC is compiled in: `rtcsel`=1, `rtcreg` = `data[2:0]`.
  - Otherwise: `rtcsel`=0, `rama` = `data[RAM_BANK_W-1:0]`.
- `addr` 011x (RTC only): latch FSM.
  - States: IDLE → ARMED on write 8'h00.
  - ARMED → IDLE on write 8'h01; this also copies all live counters to the latch registers.
  - ARMED → ARMED on 8'h00.
  - Any other value → IDLE.
- `roma` = `addr[14]` ? `romb` : 0. `romb` is never forced non-zero; bank 0 is selectable in the upper window.
- `ramsel` = `cs` | !`ramen` | (`addr[15:13]`≠3'b101) | `rtcsel` | (`rd` & `wr`).
- RTC fields: sec 6b, min 6b, hour 5b, day 9b, `halt`, `carry`.
- RTC register index: 0=sec, 1=min, 2=hour, 3=day[7:0], 4={carry, halt, 5'b0, day[8]}; indices 5..7 read 8'hFF and ignore writes.
- RTC read: `doe` = `rtcsel` & `ramen` & !`cs` & !`rd` & `addr[15:13]`==3'b101. `dout` = the latched value of `rtcreg`, registered one cycle.
- RTC write: a commit while `rtcsel` & `ramen` & `addr[15:13]`==3'b101 writes the live field, truncated to field width. A write to sec also clears the prescaler.
- Tick: while !`halt`, the prescaler counts 0..TICK_DIV-1 and fires a tick on wrap.
  - Each field increments on tick or on carry-in. At its max (59/59/23/511) it wraps to 0 and carries out.
  - A field above its max increments modulo 2^width with no carry out.
  - Day wrap sets `carry`. `carry` is sticky until written 0.

## Timing
- Reset values: `romb`=1, `rama`=0, `ramen`=0, `rtcsel`=0, `rtcreg`=0, latch FSM=IDLE.
- RTC reset values: all live and latched fields 0, prescaler 0, `halt`=0, `carry`=0, `dout`=0.
- Output values after reset: `roma` = 0 (upper window reads bank 1), `ramsel`=1, `doe`=0.
- Register write latency: a register updates at the edge of the commit cycle and is visible on `roma`/`rama`/`ramsel` the next cycle. `roma`, `rama`, `ramsel` and `doe` are combinational from registers and bus inputs.
- Simultaneous CPU write and tick: the CPU write wins for the written field, and that field's carry-in is lost. Other fields update normally.
- A latch on the same cycle as a tick captures the pre-tick values.
- `rst` low mid-strobe: reset wins. The strobe in progress does not commit after `rst` rises unless `wr` goes high and then low again.

## Configuration
- `MBC5X_RTC_EN` defined: RTC, latch FSM, `dout`/`doe` are present as described.
- Not defined:
  - `addr` 011x writes are ignored.
  - `data[3]` in a RAM-bank write is an ordinary bank bit when RAM_BANK_W=4.
  - `rtcsel` is constant 0, `doe`=0, `dout`=8'h00.
  - No RTC registers are synthesised.

## Test plan
- Reset, then ROM writes: read `addr`=4'h4 → `roma`=9'h001. Write 8'h34 @2xxx, then 8'h01 @3xxx → `roma`=9'h134. Set `addr`=4'h0 → `roma`=0.
- RAM enable and select: write 8'h0A @0xxx and 8'h05 @4xxx, then `addr`=4'hA, `cs`=0, `rd`=0 → `ramsel`=0, `rama`=4'h5. Write 8'h0B @0xxx → `ramsel`=1.
- Single commit: hold `wr` low for 10 cycles while `data` changes 8'h10→8'h20 after cycle 1 → `romb[7:0]`=8'h10.
- RTC rollover (TICK_DIV=4): write sec=59, min=59, hour=23, day=511 (including index 4), then wait 4 cycles → all fields 0 and `carry`=1. Latch 00/01 and read index 4 → `dout`=8'h80.
- Halt and latch: set `halt`, wait 3×TICK_DIV → sec unchanged. Write 00, 02, 01 @6xxx → latch not updated. Write 00, 01 → latch updated.
- Out-of-range value: write sec=62, wait 2 ticks → sec=0 and min unchanged.
